// File: rtl/level_driver_if.sv
// Request/status bundle between a level-change requester and level_driver.
interface level_driver_if;
    logic req_valid;
    logic req_level;
    logic req_ready;
    logic out;
    logic busy;
    logic done;

    modport master (
        output req_valid, req_level,
        input  req_ready, out, busy, done
    );

    modport slave (
        input  req_valid, req_level,
        output req_ready, out, busy, done
    );
endinterface

// File: rtl/level_driver.sv
// Single-bit level transmitter with guaranteed minimum hold per accepted level.
// Optional contact-bounce burst before settling: define LEVEL_DRIVER_BOUNCE_EN.
module level_driver #(
    parameter int HOLD_CYCLES = 10,
    parameter int BOUNCES     = 2,
    parameter int BOUNCE_LEN  = 1,
    parameter int CNT_W       = 8,
    parameter bit INIT        = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    level_driver_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        BOUNCE = 2'd2
    } state_t;

    if (HOLD_CYCLES < 1 || BOUNCE_LEN < 1 || BOUNCES < 0 || CNT_W < 1 ||
        (64'(HOLD_CYCLES - 1) >> CNT_W) != 64'd0 ||
        (64'(BOUNCE_LEN - 1) >> CNT_W) != 64'd0) begin : g_bad_param
        $error("level_driver: illegal parameter combination");
    end

    localparam logic [CNT_W-1:0] HOLD_RLD = CNT_W'(HOLD_CYCLES - 1);

`ifdef LEVEL_DRIVER_BOUNCE_EN
    localparam bit               BOUNCE_ACT = (BOUNCES > 0);
    localparam int               PH_W       = (BOUNCES > 0) ? $clog2(2*BOUNCES + 1) : 1;
    localparam int               PH_LAST    = BOUNCE_ACT ? 2*BOUNCES - 1 : 0;
    localparam logic [CNT_W-1:0] BL_RLD     = CNT_W'(BOUNCE_LEN - 1);

    logic [PH_W-1:0] phase;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             out_q;
    logic             done_q;
    logic             ready;
    logic             accept;

    // Ready again in the last hold cycle so continuous requests lose no cycle.
    assign ready  = (state == IDLE) || (state == HOLD && cnt == '0);
    assign accept = bus.req_valid && ready;

    assign bus.req_ready = ready;
    assign bus.busy      = (state != IDLE);
    assign bus.out       = out_q;
    assign bus.done      = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            out_q  <= INIT;
            done_q <= 1'b0;
`ifdef LEVEL_DRIVER_BOUNCE_EN
            phase  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                HOLD: begin
                    if (cnt == '0) begin
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
`ifdef LEVEL_DRIVER_BOUNCE_EN
                // Every phase boundary flips the line; the last flip lands back on the new level.
                BOUNCE: begin
                    if (cnt == '0) begin
                        out_q <= ~out_q;
                        phase <= phase + PH_W'(1);
                        if (phase == PH_W'(PH_LAST)) begin
                            state <= HOLD;
                            cnt   <= HOLD_RLD;
                        end else begin
                            cnt <= BL_RLD;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
`endif
                default: ;
            endcase

            // Acceptance overrides the HOLD->IDLE exit taken on the same edge.
            if (accept) begin
                out_q <= bus.req_level;
`ifdef LEVEL_DRIVER_BOUNCE_EN
                if (BOUNCE_ACT && bus.req_level != out_q) begin
                    state <= BOUNCE;
                    phase <= '0;
                    cnt   <= BL_RLD;
                end else begin
                    state <= HOLD;
                    cnt   <= HOLD_RLD;
                end
`else
                state <= HOLD;
                cnt   <= HOLD_RLD;
`endif
            end
        end
    end

endmodule
